// File: rtl/me_stream_if.sv
// Word-stream front end of the IDDMM modular-exponentiation engine.
// Loads X/Y operand words from the host, serves them to the core, streams results back.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   me_start                        host pulse that opens a transaction
//   me_x/me_x_valid, me_y/me_y_valid  operand word streams, LSW first
//   me_result/me_valid              result word stream, LSW first, N consecutive cycles
//   busy                            high whenever the FSM is not idle
//   core_start                      one-cycle pulse when both operands are loaded
//   core_rd_addr -> core_x/y_word   operand read port, 1-cycle registered latency
//   core_wr_en/addr/data            result write port
//   core_done                       core pulse, all result words written
module me_stream_if #(
    parameter int K = 128,
    parameter int N = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     me_start,
    input  logic [K-1:0]             me_x,
    input  logic                     me_x_valid,
    input  logic [K-1:0]             me_y,
    input  logic                     me_y_valid,
    output logic [K-1:0]             me_result,
    output logic                     me_valid,
    output logic                     busy,
    output logic                     core_start,
    input  logic [$clog2(N)-1:0]     core_rd_addr,
    output logic [K-1:0]             core_x_word,
    output logic [K-1:0]             core_y_word,
    input  logic                     core_wr_en,
    input  logic [$clog2(N)-1:0]     core_wr_addr,
    input  logic [K-1:0]             core_wr_data,
    input  logic                     core_done
);

    localparam int ADDR_W = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    localparam logic [ADDR_W:0] NC  = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

    logic [1:0]      state;
    logic [ADDR_W:0] cnt_x;
    logic [ADDR_W:0] cnt_y;
    logic [ADDR_W:0] rd_ptr;

    logic [K-1:0] x_mem [N];
    logic [K-1:0] y_mem [N];
    logic [K-1:0] r_mem [N];

    // First stage of the two-stage send pipeline: buffer read
    logic [K-1:0] snd_data;
    logic         snd_vld;

    logic x_take;
    logic y_take;
    logic x_full;
    logic y_full;
    logic rd_ok;
    logic wr_ok;

    // Counters saturate at N so trailing words are simply dropped
    assign x_take = (state == S_LOAD) && me_x_valid && (cnt_x != NC);
    assign y_take = (state == S_LOAD) && me_y_valid && (cnt_y != NC);

    // Full as of the end of this cycle, so core_start lands right after the last word
    assign x_full = (cnt_x == NC) || (x_take && (cnt_x == NC - ONE));
    assign y_full = (cnt_y == NC) || (y_take && (cnt_y == NC - ONE));

    assign rd_ok = {1'b0, core_rd_addr} < NC;
    assign wr_ok = {1'b0, core_wr_addr} < NC;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (x_take) x_mem[cnt_x[ADDR_W-1:0]] <= me_x;
        if (y_take) y_mem[cnt_y[ADDR_W-1:0]] <= me_y;
        if ((state == S_RUN) && core_wr_en && wr_ok)
            r_mem[core_wr_addr] <= core_wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt_x       <= '0;
            cnt_y       <= '0;
            rd_ptr      <= '0;
            snd_data    <= '0;
            snd_vld     <= 1'b0;
            me_result   <= '0;
            me_valid    <= 1'b0;
            core_start  <= 1'b0;
            core_x_word <= '0;
            core_y_word <= '0;
        end else begin
            core_start  <= 1'b0;
            snd_vld     <= 1'b0;
            core_x_word <= rd_ok ? x_mem[core_rd_addr] : '0;
            core_y_word <= rd_ok ? y_mem[core_rd_addr] : '0;
            me_valid    <= snd_vld;
            me_result   <= snd_vld ? snd_data : '0;

            case (state)
                S_IDLE: begin
                    if (me_start) begin
                        state <= S_LOAD;
                        cnt_x <= '0;
                        cnt_y <= '0;
                    end
                end
                S_LOAD: begin
                    if (x_take) cnt_x <= cnt_x + ONE;
                    if (y_take) cnt_y <= cnt_y + ONE;
                    if (x_full && y_full) begin
                        state      <= S_RUN;
                        core_start <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (core_done) begin
                        state  <= S_SEND;
                        rd_ptr <= '0;
                    end
                end
                S_SEND: begin
                    if (rd_ptr != NC) begin
                        snd_vld  <= 1'b1;
                        snd_data <= r_mem[rd_ptr[ADDR_W-1:0]];
                        rd_ptr   <= rd_ptr + ONE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
